gate_bist_checker: RTL

//  Hardware self-test engine for a 2-input logic gate under test (GUT): drives input patterns, samples the gate output, checks it.

---
 rtl/gate_bist_pkg.sv | 45 ++++
 rtl/gate_bist_checker_if.sv | 37 +++
 rtl/gate_bist_seq.sv | 54 +++++
 rtl/gate_bist_checker.sv | 121 ++++++++++++
 4 files changed

// File: rtl/gate_bist_pkg.sv
// Shared types for the 2-input gate self-test engine: op encoding, FSM states,
// stimulus pattern table and the reference gate function.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_CHECK  = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    localparam int NUM_PAT = 6;

    // Entry i sits at bits [2i+1:2i] as {a,b}: full truth table then the 00/11 toggle pair.
    localparam logic [2*NUM_PAT-1:0] PAT_TBL = {2'b11, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00};

    function automatic logic [1:0] pat_at(input logic [2:0] idx);
        logic [1:0] p;
        p = 2'b00;
        if (idx < 3'(NUM_PAT)) begin
            p = PAT_TBL[{idx, 1'b0} +: 2];
        end
        return p;
    endfunction

    function automatic logic exp_y(input op_e op, input logic a, input logic b);
        logic y;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/gate_bist_checker_if.sv
// Control/status and gate-under-test signals of the gate self-test engine.
// GATE_BIST_FIRST_FAIL_EN adds the first-fail capture signals.
interface gate_bist_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic [1:0]       op;
    logic             dut_a;
    logic             dut_b;
    logic             dut_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
`ifdef GATE_BIST_FIRST_FAIL_EN
    logic             ff_valid;
    logic [1:0]       ff_vec;

    modport master (
        output start, op, dut_y,
        input  dut_a, dut_b, busy, done, pass, err_cnt, ff_valid, ff_vec
    );
    modport slave (
        input  start, op, dut_y,
        output dut_a, dut_b, busy, done, pass, err_cnt, ff_valid, ff_vec
    );
`else
    modport master (
        output start, op, dut_y,
        input  dut_a, dut_b, busy, done, pass, err_cnt
    );
    modport slave (
        input  start, op, dut_y,
        output dut_a, dut_b, busy, done, pass, err_cnt
    );
`endif
endinterface

// File: rtl/gate_bist_seq.sv
// Pattern sequencer: settle counter, pattern index and loop counter; emits next pattern and end flags.
// Latency: flags are combinational from registered counters; no backpressure, steps only when told.
// No flow control: clear/cnt_en/advance come from the checker FSM.
module gate_bist_seq
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       cnt_en,
    input  logic       advance,
    output logic       settle_last,
    output logic       last,
    output logic [1:0] nxt_pat
);
    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        idx_q;
    logic [LOOP_W-1:0] loop_q;
    logic              idx_end;

    assign idx_end     = (idx_q == 3'(NUM_PAT - 1));
    assign settle_last = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
    assign last        = idx_end && (loop_q == LOOP_W'(LOOPS - 1));
    assign nxt_pat     = pat_at(idx_end ? 3'd0 : idx_q + 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            loop_q <= '0;
        end else if (clear) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            loop_q <= '0;
        end else if (advance) begin
            cnt_q <= '0;
            if (idx_end) begin
                idx_q  <= '0;
                loop_q <= loop_q + 1'b1;
            end else begin
                idx_q <= idx_q + 3'd1;
            end
        end else if (cnt_en && !settle_last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/gate_bist_checker.sv
// Gate self-test engine: drives 6 patterns per loop into a 2-input gate, checks its output, counts errors.
// Latency: done pulses 6*LOOPS*(SETTLE_CYCLES+1)+1 cycles after start accept; optional GATE_BIST_FIRST_FAIL_EN.
// No backpressure: start is only sampled in IDLE, ignored while busy.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    gate_bist_checker_if.slave   bus
);
    state_e           state_q, state_d;
    op_e              op_q;
    logic             dut_a_q, dut_b_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_q;
    logic             accept;
    logic             mismatch;
    logic             settle_last;
    logic             last;
    logic [1:0]       nxt_pat;

    gate_bist_seq #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .LOOPS         (LOOPS)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .clear       (accept),
        .cnt_en      (state_q == ST_SETTLE),
        .advance     ((state_q == ST_CHECK) && !last),
        .settle_last (settle_last),
        .last        (last),
        .nxt_pat     (nxt_pat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_last) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: state_d = last ? ST_DONE : ST_SETTLE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign mismatch = (state_q == ST_CHECK) && (bus.dut_y != exp_y(op_q, dut_a_q, dut_b_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_AND;
            dut_a_q <= 1'b0;
            dut_b_q <= 1'b0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else if (accept) begin
            op_q               <= op_e'(bus.op);
            {dut_a_q, dut_b_q} <= pat_at(3'd0);
            err_q              <= '0;
            pass_q             <= 1'b0;
        end else if (state_q == ST_CHECK) begin
            if (mismatch && (err_q != '1)) begin
                err_q <= err_q + 1'b1;
            end
            // Next pattern launches on the same edge that samples this one.
            {dut_a_q, dut_b_q} <= last ? 2'b00 : nxt_pat;
        end else if (state_q == ST_DONE) begin
            pass_q <= (err_q == '0);
        end
    end

`ifdef GATE_BIST_FIRST_FAIL_EN
    logic       ff_valid_q;
    logic [1:0] ff_vec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_valid_q <= 1'b0;
            ff_vec_q   <= 2'b00;
        end else if (accept) begin
            ff_valid_q <= 1'b0;
        end else if (mismatch && !ff_valid_q) begin
            ff_valid_q <= 1'b1;
            ff_vec_q   <= {dut_a_q, dut_b_q};
        end
    end

    assign bus.ff_valid = ff_valid_q;
    assign bus.ff_vec   = ff_vec_q;
`endif

    assign bus.dut_a   = dut_a_q;
    assign bus.dut_b   = dut_b_q;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_q;

endmodule
